// File: rtl/freq_div_pkg.sv
// freq_div_pkg
//   Shared constants for the divide-by-3 clock divider.
//   DIV_RATIO : fixed division ratio (not overridable)
//   CNT_W     : phase counter width
//   PH0..PH2  : legal phase counter values; any other value is illegal
//   next_phase: phase successor, folding illegal codes back to PH0
`timescale 1ns/1ps
package freq_div_pkg;

  localparam int unsigned DIV_RATIO = 3;
  localparam int unsigned CNT_W     = 2;

  typedef logic [CNT_W-1:0] phase_t;

  localparam phase_t PH0 = phase_t'(0);
  localparam phase_t PH1 = phase_t'(1);
  localparam phase_t PH2 = phase_t'(2);

  // Last legal phase; q_pos is set on the edge that leaves it.
  localparam phase_t PH_LAST = phase_t'(DIV_RATIO - 1);

  // 0 -> 1 -> 2 -> 0. The unused code (3) returns to PH0 so a corrupted
  // counter recovers within one edge instead of locking up.
  function automatic phase_t next_phase(input phase_t cur);
    phase_t nxt;
    nxt = PH0;
    case (cur)
      PH0:     nxt = PH1;
      PH1:     nxt = PH2;
      PH2:     nxt = PH0;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/frequency_divider_by_3.sv
// frequency_divider_by_3
//   Divides clk by 3. Flop-based and latch-free so it behaves the same in
//   RTL and SDF-annotated gate-level simulation.
//   Default build : out_clk = q_pos, 1/3 duty, driven straight from a flop.
//   DUTY50_EN     : adds a negedge retime of q_pos; out_clk = q_pos | q_neg
//                   gives 50% duty (rises on posedge, falls on negedge).
// Ports
//   clk     in  1  reference clock
//   rst     in  1  asynchronous reset, active low
//   out_clk out 1  divided clock, period = 3 clk periods
`timescale 1ns/1ps
module frequency_divider_by_3
  import freq_div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic out_clk
);

  phase_t cnt;
  phase_t cnt_nxt;
  logic   q_pos;
  logic   q_pos_nxt;

  always_comb begin
    cnt_nxt   = next_phase(cnt);
    q_pos_nxt = 1'b0;
    if (cnt == PH_LAST) q_pos_nxt = 1'b1;
  end

  // Phase counter and posedge pulse. After reset release the counter walks
  // 0->1->2 on the first two edges, and the third edge (leaving phase 2)
  // sets q_pos, giving the first rise on the 3rd posedge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= PH0;
      q_pos <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      q_pos <= q_pos_nxt;
    end
  end

`ifdef DUTY50_EN
  logic q_neg;

  // Half-cycle delayed copy of q_pos. Its pulse overlaps q_pos by half a
  // clk period, so the OR never dips low between them.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) q_neg <= 1'b0;
    else      q_neg <= q_pos;
  end

  assign out_clk = q_pos | q_neg;
`else
  assign out_clk = q_pos;
`endif

endmodule

// File: tb/tb_frequency_divider_by_3.sv
`timescale 1ns/1ps
module tb_frequency_divider_by_3;

  logic clk;
  logic rst;
  logic out_clk;

  int errors = 0;
  int checks = 0;

`ifdef DUTY50_EN
  localparam real HIGH_T = 7.5;
`else
  localparam real HIGH_T = 5.0;
`endif

  frequency_divider_by_3 dut (
    .clk    (clk),
    .rst    (rst),
    .out_clk(out_clk)
  );

  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  // Edge monitors for timing checks
  real last_rise = -1.0;
  real prev_rise = -1.0;
  real hi_min = 1.0e9;
  real hi_max = -1.0;
  int  rise_cnt = 0;
  int  bad_space = 0;
  bit  win = 1'b0;

  always @(posedge out_clk) begin
    prev_rise = last_rise;
    last_rise = $realtime;
    if (win) begin
      rise_cnt++;
      if (prev_rise >= 0.0 && ($realtime - prev_rise) != 15.0) bad_space++;
    end
  end

  always @(negedge out_clk) begin
    if (win) begin
      if ($realtime - last_rise < hi_min) hi_min = $realtime - last_rise;
      if ($realtime - last_rise > hi_max) hi_max = $realtime - last_rise;
    end
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_t(input string tag, input real obs, input real exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: got %0.3f expected %0.3f", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    // 1. reset hold
    #0.1 chk("reset_t0", {1'b0, out_clk}, 2'b00);
    #2.5 chk("reset_hold_edge", {1'b0, out_clk}, 2'b00);   // t=2.6
    chk("reset_cnt", dut.cnt, 2'd0);
    #2.4 rst = 1'b1;                                       // t=5.0

    // 2. first edges after release
    #3.5 chk("edge1_low", {1'b0, out_clk}, 2'b00);         // t=8.5
    #5.0 chk("edge2_low", {1'b0, out_clk}, 2'b00);         // t=13.5
    #5.0 chk("edge3_high", {1'b0, out_clk}, 2'b01);        // t=18.5
    chk_t("first_rise_time", last_rise, 17.5);
`ifdef DUTY50_EN
    #5.0 chk("still_high_23p5", {1'b0, out_clk}, 2'b01);   // t=23.5
    #2.0 chk("fall_25", {1'b0, out_clk}, 2'b00);           // t=25.5
    #2.5;                                                  // t=28.0
`else
    #5.0 chk("fall_22p5", {1'b0, out_clk}, 2'b00);         // t=23.5
    #4.5;                                                  // t=28.0
`endif

    // 3. free-run 30 periods: rises at 32.5 .. 167.5
    win = 1'b1;
    #150.0 win = 1'b0;                                     // t=178.0
    chk_i("rise_count", rise_cnt, 10);
    chk_i("rise_spacing", bad_space, 0);
    chk_t("high_min", hi_min, HIGH_T);
    chk_t("high_max", hi_max, HIGH_T);

    // 4. async reset while high (rise at 182.5)
    #5.0 chk("pre_reset_high", {1'b0, out_clk}, 2'b01);    // t=183.0
    rst = 1'b0;
    #0.1 chk("async_reset_low", {1'b0, out_clk}, 2'b00);
    chk("async_reset_cnt", dut.cnt, 2'd0);
    #7.9 rst = 1'b1;                                       // t=191.0
    #2.5 chk("rel_edge1_low", {1'b0, out_clk}, 2'b00);     // t=193.5
    #5.0 chk("rel_edge2_low", {1'b0, out_clk}, 2'b00);     // t=198.5
    #5.0 chk("rel_edge3_high", {1'b0, out_clk}, 2'b01);    // t=203.5
    chk_t("rel_rise_time", last_rise, 202.5);

    // 5. illegal counter value recovers
    #2.5 force dut.cnt = 2'd3;                             // t=206.0
    #0.5 chk("forced_cnt", dut.cnt, 2'd3);
    release dut.cnt;
    #2.0 chk("illegal_to_0", dut.cnt, 2'd0);               // t=208.5
`ifdef DUTY50_EN
    chk("illegal_out", {1'b0, out_clk}, 2'b01);
`else
    chk("illegal_out", {1'b0, out_clk}, 2'b00);
`endif
    #5.0 chk("recov_cnt1", dut.cnt, 2'd1);                 // t=213.5
    chk("recov_low1", {1'b0, out_clk}, 2'b00);
    #5.0 chk("recov_low2", {1'b0, out_clk}, 2'b00);        // t=218.5
    #5.0 chk("recov_high", {1'b0, out_clk}, 2'b01);        // t=223.5
    chk_t("recov_rise_time", last_rise, 222.5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
